sme_char_loader: RTL

//  Input stage of the SME string-match engine. Captures the serial 8-bit character stream (string

---
 rtl/sme_char_loader_if.sv | 30 +++
 rtl/sme_char_loader.sv | 115 +++++++++++
 2 files changed

// File: rtl/sme_char_loader_if.sv
// Character-stream bus of the SME input stage: serial char inputs plus the
// captured string/pattern buffers handed on to the pe_slave array.
interface sme_char_loader_if #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8
);
  localparam int unsigned SCW = $clog2(STR_MAX + 1);
  localparam int unsigned PCW = $clog2(PAT_MAX + 1);

  logic [7:0]           chardata;
  logic                 isstring;
  logic                 ispattern;
  logic [8*STR_MAX-1:0] str_reg;
  logic [8*PAT_MAX-1:0] pat_reg;
  logic [SCW-1:0]       str_last_idx;
  logic [PCW-1:0]       pat_last_idx;
  logic                 valid;
  logic                 str_loaded;
  logic                 ovf;

  modport master (
    output chardata, isstring, ispattern,
    input  str_reg, pat_reg, str_last_idx, pat_last_idx, valid, str_loaded, ovf
  );

  modport slave (
    input  chardata, isstring, ispattern,
    output str_reg, pat_reg, str_last_idx, pat_last_idx, valid, str_loaded, ovf
  );
endinterface

// File: rtl/sme_char_loader.sv
// SME input stage: packs the serial string/pattern char stream into flat
// buffers and pulses valid once a complete pattern has been received.
module sme_char_loader #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  sme_char_loader_if.slave  bus
);
  localparam int unsigned SCW = $clog2(STR_MAX + 1);
  localparam int unsigned PCW = $clog2(PAT_MAX + 1);
  localparam logic [SCW-1:0] STR_FULL = SCW'(STR_MAX);
  localparam logic [PCW-1:0] PAT_FULL = PCW'(PAT_MAX);

  typedef enum logic [1:0] {IDLE, STR, PAT} state_t;

  state_t               r_state,      w_state_nxt;
  logic [8*STR_MAX-1:0] r_str_reg,    w_str_reg_nxt;
  logic [8*PAT_MAX-1:0] r_pat_reg,    w_pat_reg_nxt;
  logic [SCW-1:0]       r_str_cnt,    w_str_cnt_nxt;
  logic [PCW-1:0]       r_pat_cnt,    w_pat_cnt_nxt;
  logic [SCW-1:0]       r_str_last,   w_str_last_nxt;
  logic [PCW-1:0]       r_pat_last,   w_pat_last_nxt;
  logic                 r_valid,      w_valid_nxt;
  logic                 r_str_loaded, w_str_loaded_nxt;
  logic                 r_ovf,        w_ovf_nxt;

  logic w_str_sel;
  logic w_pat_sel;

  // isstring has priority when both strobes are high
  assign w_str_sel = bus.isstring;
  assign w_pat_sel = bus.ispattern & ~bus.isstring;

  always_comb begin
    w_state_nxt      = IDLE;
    w_str_reg_nxt    = r_str_reg;
    w_pat_reg_nxt    = r_pat_reg;
    w_str_cnt_nxt    = r_str_cnt;
    w_pat_cnt_nxt    = r_pat_cnt;
    w_str_last_nxt   = r_str_last;
    w_pat_last_nxt   = r_pat_last;
    w_str_loaded_nxt = r_str_loaded;
    w_ovf_nxt        = r_ovf;
    w_valid_nxt      = (r_state == PAT) && !w_pat_sel;

    if (w_str_sel) begin
      w_state_nxt      = STR;
      w_str_loaded_nxt = 1'b1;
      if (r_state != STR) begin
        w_str_reg_nxt      = '0;
        w_str_reg_nxt[7:0] = bus.chardata;
        w_str_cnt_nxt      = SCW'(1);
        w_str_last_nxt     = '0;
      end else if (r_str_cnt < STR_FULL) begin
        for (int unsigned i = 0; i < STR_MAX; i++)
          if (r_str_cnt == SCW'(i)) w_str_reg_nxt[8*i +: 8] = bus.chardata;
        w_str_cnt_nxt  = r_str_cnt + SCW'(1);
        w_str_last_nxt = r_str_cnt;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end else if (w_pat_sel) begin
      w_state_nxt = PAT;
      if (r_state != PAT) begin
        w_pat_reg_nxt      = '0;
        w_pat_reg_nxt[7:0] = bus.chardata;
        w_pat_cnt_nxt      = PCW'(1);
        w_pat_last_nxt     = '0;
      end else if (r_pat_cnt < PAT_FULL) begin
        for (int unsigned i = 0; i < PAT_MAX; i++)
          if (r_pat_cnt == PCW'(i)) w_pat_reg_nxt[8*i +: 8] = bus.chardata;
        w_pat_cnt_nxt  = r_pat_cnt + PCW'(1);
        w_pat_last_nxt = r_pat_cnt;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_str_reg    <= '0;
      r_pat_reg    <= '0;
      r_str_cnt    <= '0;
      r_pat_cnt    <= '0;
      r_str_last   <= '0;
      r_pat_last   <= '0;
      r_valid      <= 1'b0;
      r_str_loaded <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_str_reg    <= w_str_reg_nxt;
      r_pat_reg    <= w_pat_reg_nxt;
      r_str_cnt    <= w_str_cnt_nxt;
      r_pat_cnt    <= w_pat_cnt_nxt;
      r_str_last   <= w_str_last_nxt;
      r_pat_last   <= w_pat_last_nxt;
      r_valid      <= w_valid_nxt;
      r_str_loaded <= w_str_loaded_nxt;
      r_ovf        <= w_ovf_nxt;
    end
  end

  assign bus.str_reg      = r_str_reg;
  assign bus.pat_reg      = r_pat_reg;
  assign bus.str_last_idx = r_str_last;
  assign bus.pat_last_idx = r_pat_last;
  assign bus.valid        = r_valid;
  assign bus.str_loaded   = r_str_loaded;
  assign bus.ovf          = r_ovf;
endmodule
